step_rate_histogram: RTL and testbench

//  Parametrised successor to the fitness step counter. Counts step pulses on X
//  and measures the step rate over fixed time windows. Each active window
//  (1 s at default settings) adds one second to one of NUM_BINS rate bins,

---
 rtl/step_rate_histogram.sv | 141 ++++++++++++++
 tb/tb_step_rate_histogram.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/step_rate_histogram.sv
// Step-rate histogram: counts synchronised step edges, measures steps per fixed
// window and accumulates one second of activity time into a rate bin per
// non-empty window. Bins are read back combinationally via rd_bin.
module step_rate_histogram #(
  parameter int unsigned TICK_DIV      = 166667,
  parameter int unsigned TICKS_PER_WIN = 600,
  parameter int unsigned NUM_BINS      = 8,
  parameter int unsigned RATE_STEP     = 4,
  parameter int unsigned RATE_W        = 8,
  parameter int unsigned TIME_W        = 17,
  parameter int unsigned STEP_W        = 24,
  parameter int unsigned MIN_ACTIVE    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        X,
  input  logic                        clear,
  input  logic [$clog2(NUM_BINS)-1:0] rd_bin,
  output logic [TIME_W-1:0]           rd_seconds,
  output logic [STEP_W-1:0]           total_steps,
  output logic [RATE_W-1:0]           last_rate,
  output logic                        window_done,
  output logic                        active
);

  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW    = (TICKS_PER_WIN > 1) ? $clog2(TICKS_PER_WIN) : 1;
  localparam int unsigned BW    = $clog2(NUM_BINS);
  localparam int unsigned SHIFT = $clog2(RATE_STEP);

  logic              x_meta_q, x_sync_q, x_prev_q;
  logic              step_edge;
  logic [PW-1:0]     presc_q;
  logic [TW-1:0]     tick_cnt_q;
  logic              tick, win_close;
  logic [RATE_W-1:0] win_steps_q;
  logic [RATE_W-1:0] win_n;
  logic [RATE_W-1:0] rate_shr;
  logic [BW-1:0]     bin_idx;
  logic [STEP_W-1:0] total_q;
  logic [RATE_W-1:0] last_rate_q;
  logic              window_done_q, active_q;
  logic [TIME_W-1:0] bin_q [NUM_BINS];

  // Two-flop synchroniser plus previous-value flop for rising-edge detection.
  // Not touched by clear, so an edge landing on a clear cycle is simply lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_meta_q <= 1'b0;
      x_sync_q <= 1'b0;
      x_prev_q <= 1'b0;
    end else begin
      x_meta_q <= X;
      x_sync_q <= x_meta_q;
      x_prev_q <= x_sync_q;
    end
  end

  assign step_edge = x_sync_q & ~x_prev_q;
  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign win_close = tick && (tick_cnt_q == TW'(TICKS_PER_WIN - 1));

  // Closing-window count includes a step edge arriving on the close cycle.
  always_comb begin
    win_n = win_steps_q;
    if (step_edge && !(&win_steps_q)) win_n = win_steps_q + RATE_W'(1);
    rate_shr = win_n >> SHIFT;
    if (32'(rate_shr) >= NUM_BINS) bin_idx = BW'(NUM_BINS - 1);
    else                           bin_idx = BW'(rate_shr);
  end

  // Prescaler and tick counter forming the measurement window timebase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      tick_cnt_q <= '0;
    end else if (clear) begin
      presc_q    <= '0;
      tick_cnt_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) tick_cnt_q <= win_close ? '0 : tick_cnt_q + TW'(1);
    end
  end

  // Step totals, per-window count and window-close results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q       <= '0;
      win_steps_q   <= '0;
      last_rate_q   <= '0;
      window_done_q <= 1'b0;
      active_q      <= 1'b0;
    end else if (clear) begin
      total_q       <= '0;
      win_steps_q   <= '0;
      last_rate_q   <= '0;
      window_done_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      window_done_q <= win_close;
      if (step_edge && !(&total_q)) total_q <= total_q + STEP_W'(1);
      if (win_close) begin
        last_rate_q <= win_n;
        active_q    <= (32'(win_n) >= MIN_ACTIVE);
        win_steps_q <= '0;
      end else begin
        win_steps_q <= win_n;
      end
    end
  end

  // Histogram accumulators; idle windows (n == 0) leave every bin untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BINS; i++) begin
        if (win_close && (win_n != '0) && (bin_idx == BW'(i)) && !(&bin_q[i])) begin
          bin_q[i] <= bin_q[i] + TIME_W'(1);
        end
      end
    end
  end

  // Bin readout; an index with no matching bin reads as zero.
  always_comb begin
    rd_seconds = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      if (rd_bin == BW'(i)) rd_seconds = bin_q[i];
    end
  end

  assign total_steps = total_q;
  assign last_rate   = last_rate_q;
  assign window_done = window_done_q;
  assign active      = active_q;

endmodule

// File: tb/tb_step_rate_histogram.sv
// Directed bench for step_rate_histogram: a 40-clk window instance for binning,
// boundary and clear behaviour, and a narrow-width instance for saturation.
module tb_step_rate_histogram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x1 = 1'b0, clear1 = 1'b0;
  logic [1:0]  rd_bin1 = '0;
  logic [16:0] rd_seconds1;
  logic [23:0] total1;
  logic [7:0]  last_rate1;
  logic        done1, active1;

  logic        x2 = 1'b0, clear2 = 1'b0;
  logic [1:0]  rd_bin2 = '0;
  logic [1:0]  rd_seconds2;
  logic [23:0] total2;
  logic [2:0]  last_rate2;
  logic        done2, active2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  always #5 clk = ~clk;

  step_rate_histogram #(
    .TICK_DIV(4), .TICKS_PER_WIN(10), .NUM_BINS(4), .RATE_STEP(4),
    .RATE_W(8), .TIME_W(17), .STEP_W(24), .MIN_ACTIVE(1)
  ) u_dut (
    .clk(clk), .rst(rst), .X(x1), .clear(clear1), .rd_bin(rd_bin1),
    .rd_seconds(rd_seconds1), .total_steps(total1), .last_rate(last_rate1),
    .window_done(done1), .active(active1)
  );

  step_rate_histogram #(
    .TICK_DIV(4), .TICKS_PER_WIN(10), .NUM_BINS(4), .RATE_STEP(4),
    .RATE_W(3), .TIME_W(2), .STEP_W(24), .MIN_ACTIVE(1)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .X(x2), .clear(clear2), .rd_bin(rd_bin2),
    .rd_seconds(rd_seconds2), .total_steps(total2), .last_rate(last_rate2),
    .window_done(done2), .active(active2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits (bounded) for window_done of the selected instance, sampled at negedge.
  task automatic wait_done(input bit sel, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sel ? done2 : done1) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) check_eq("window_done_timeout", 32'd0, 32'd1);
  endtask

  // n single-cycle-high pulses, one step per two clocks.
  task automatic pulses(input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      if (sel) x2 = 1'b1; else x1 = 1'b1;
      @(negedge clk);
      if (sel) x2 = 1'b0; else x1 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_bin(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    rd_bin1 = idx;
    #1;
    check_eq(tag, rd_seconds1, exp);
  endtask

  initial begin
    // Reset held while X toggles: everything stays zero.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      x1 = ~x1;
    end
    @(negedge clk);
    x1 = 1'b0;
    check_eq("rst_total", total1, 0);
    check_eq("rst_last_rate", last_rate1, 0);
    check_eq("rst_done", done1, 0);
    check_eq("rst_active", active1, 0);
    for (int b = 0; b < 4; b++) check_bin("rst_bin", 2'(b), 0);
    rst = 1'b0;

    wait_done(1'b0, cyc);
    check_eq("first_done_cycle", cyc, 40);
    check_eq("empty_last_rate", last_rate1, 0);
    check_eq("empty_active", active1, 0);

    // Window A: 5 steps -> bin 1.
    pulses(5, 1'b0);
    wait_done(1'b0, cyc);
    check_eq("winA_last_rate", last_rate1, 5);
    check_eq("winA_active", active1, 1);
    @(negedge clk);
    check_eq("done_one_cycle", done1, 0);
    // Window B starts 1 clk late, still well inside: 13 steps -> bin 3.
    pulses(13, 1'b0);
    wait_done(1'b0, cyc);
    check_eq("winB_last_rate", last_rate1, 13);
    check_eq("winB_total", total1, 18);
    check_bin("winB_bin0", 2'd0, 0);
    check_bin("winB_bin1", 2'd1, 1);
    check_bin("winB_bin2", 2'd2, 0);
    check_bin("winB_bin3", 2'd3, 1);

    // Window C: 18 steps, 18>>2=4 clamps to bin 3.
    pulses(18, 1'b0);
    wait_done(1'b0, cyc);
    check_eq("winC_last_rate", last_rate1, 18);
    check_bin("winC_bin3", 2'd3, 2);
    // Window D: idle.
    wait_done(1'b0, cyc);
    check_eq("winD_last_rate", last_rate1, 0);
    check_eq("winD_active", active1, 0);
    check_bin("winD_bin3", 2'd3, 2);
    check_bin("winD_bin1", 2'd1, 1);
    check_eq("winD_total", total1, 36);

    // Window E: X rises so its edge lands on the close cycle, then stays high.
    repeat (37) @(negedge clk);
    x1 = 1'b1;
    wait_done(1'b0, cyc);
    check_eq("edge_close_cycle", cyc, 3);
    check_eq("winE_last_rate", last_rate1, 1);
    check_eq("winE_active", active1, 1);
    check_bin("winE_bin0", 2'd0, 1);
    repeat (7) @(negedge clk);
    x1 = 1'b0;
    wait_done(1'b0, cyc);
    check_eq("winF_last_rate", last_rate1, 0);
    check_eq("held_high_total", total1, 37);

    // Window G: 2 steps -> bin 0.
    pulses(2, 1'b0);
    wait_done(1'b0, cyc);
    check_eq("winG_last_rate", last_rate1, 2);
    check_eq("winG_total", total1, 39);
    check_bin("winG_bin0", 2'd0, 2);

    // Window H: 3 steps, then clear on the same edge a further step arrives.
    pulses(3, 1'b0);
    repeat (9) @(negedge clk);
    x1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear1 = 1'b1;
    @(negedge clk);
    clear1 = 1'b0;
    x1 = 1'b0;
    check_eq("clr_total", total1, 0);
    check_eq("clr_last_rate", last_rate1, 0);
    check_eq("clr_active", active1, 0);
    check_eq("clr_done", done1, 0);
    for (int b = 0; b < 4; b++) check_bin("clr_bin", 2'(b), 0);
    wait_done(1'b0, cyc);
    check_eq("clr_done_cycle", cyc, 40);
    check_eq("clr_after_last_rate", last_rate1, 0);
    check_eq("clr_after_total", total1, 0);

    // Saturation instance: align its window with clear, then 10 steps.
    @(negedge clk);
    clear2 = 1'b1;
    @(negedge clk);
    clear2 = 1'b0;
    pulses(10, 1'b1);
    wait_done(1'b1, cyc);
    check_eq("sat_last_rate", last_rate2, 7);
    check_eq("sat_active", active2, 1);
    for (int w = 0; w < 4; w++) begin
      pulses(5, 1'b1);
      wait_done(1'b1, cyc);
    end
    check_eq("sat_last_rate5", last_rate2, 5);
    check_eq("sat_total", total2, 30);
    rd_bin2 = 2'd1;
    #1;
    check_eq("sat_bin1", rd_seconds2, 3);
    rd_bin2 = 2'd0;
    #1;
    check_eq("sat_bin0", rd_seconds2, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
